// File: rtl/acc_seq8.sv
// 8-bit accumulator sequencer driving an external combinational add/sub unit; rsp_valid two cycles after acceptance.
// Backpressure: cmd_ready is low only in EXEC, so commands can be accepted every other cycle.
module acc_seq8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_usec,
    output logic [7:0] as_a,
    output logic [7:0] as_b,
    output logic       as_cin,
    output logic       as_op,
    input  logic [7:0] as_result,
    input  logic       as_cout,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v,
    output logic       rsp_valid,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0] state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] as_a_q, as_a_d;
    logic [7:0] as_b_q, as_b_d;
    logic       as_cin_q, as_cin_d;
    logic       as_op_q, as_op_d;
    logic [1:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic       flag_c_q, flag_c_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_n_q, flag_n_d;
    logic       flag_v_q, flag_v_d;

    logic cmd_accept;
    logic add_v;
    logic sub_v;

    assign cmd_ready  = (state_q != ST_EXEC);
    assign cmd_accept = cmd_valid & cmd_ready;

    // Signed overflow from the operands as launched, not the live command inputs.
    assign add_v = (as_a_q[7] == as_b_q[7]) & (as_result[7] != as_a_q[7]);
    assign sub_v = (as_a_q[7] != as_b_q[7]) & (as_result[7] != as_a_q[7]);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        as_a_d   = as_a_q;
        as_b_d   = as_b_q;
        as_cin_d = as_cin_q;
        as_op_d  = as_op_q;
        op_d     = op_q;
        data_d   = data_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        flag_v_d = flag_v_q;

        if (cmd_accept) begin
            as_a_d   = acc_q;
            as_b_d   = cmd_data;
            as_op_d  = cmd_op[1];
            as_cin_d = cmd_usec & flag_c_q;
            op_d     = cmd_op;
            data_d   = cmd_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_LOAD: begin
                        acc_d    = data_q;
                        flag_z_d = (data_q == 8'h00);
                        flag_n_d = data_q[7];
                    end
                    OP_ADD, OP_SUB: begin
                        acc_d    = as_result;
                        flag_c_d = as_cout;
                        flag_z_d = (as_result == 8'h00);
                        flag_n_d = as_result[7];
                        flag_v_d = (op_q == OP_ADD) ? add_v : sub_v;
                    end
                    OP_CLEAR: begin
                        acc_d    = 8'h00;
                        flag_c_d = 1'b0;
                        flag_z_d = 1'b1;
                        flag_n_d = 1'b0;
                        flag_v_d = 1'b0;
                    end
                    default: begin
                        acc_d = acc_q;
                    end
                endcase
            end
            ST_DONE: begin
                state_d = cmd_accept ? ST_EXEC : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= 8'h00;
            as_a_q   <= 8'h00;
            as_b_q   <= 8'h00;
            as_cin_q <= 1'b0;
            as_op_q  <= 1'b0;
            op_q     <= OP_LOAD;
            data_q   <= 8'h00;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            as_a_q   <= as_a_d;
            as_b_q   <= as_b_d;
            as_cin_q <= as_cin_d;
            as_op_q  <= as_op_d;
            op_q     <= op_d;
            data_q   <= data_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign as_a      = as_a_q;
    assign as_b      = as_b_q;
    assign as_cin    = as_cin_q;
    assign as_op     = as_op_q;
    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_EXEC);

endmodule

// File: tb/tb_acc_seq8.sv
// Directed bench for acc_seq8 with a behavioural model of the external add/sub unit.
module tb_acc_seq8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic       usec;
        logic       cin;
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_usec;
    logic [7:0] as_a;
    logic [7:0] as_b;
    logic       as_cin;
    logic       as_op;
    logic [7:0] as_result;
    logic       as_cout;
    logic [7:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic       rsp_valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    logic [7:0] model_acc;
    logic [8:0] sum;
    vec_t vecs [18];

    acc_seq8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_usec  (cmd_usec),
        .as_a      (as_a),
        .as_b      (as_b),
        .as_cin    (as_cin),
        .as_op     (as_op),
        .as_result (as_result),
        .as_cout   (as_cout),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .rsp_valid (rsp_valid),
        .busy      (busy)
    );

    // External combinational add/sub unit.
    always_comb begin
        if (!as_op) sum = {1'b0, as_a} + {1'b0, as_b} + {8'd0, as_cin};
        else        sum = {1'b0, as_a} - {1'b0, as_b} - {8'd0, as_cin};
    end
    assign as_result = sum[7:0];
    assign as_cout   = sum[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] d, input logic u,
                                input logic cin, input logic [7:0] a, input logic c,
                                input logic z, input logic n, input logic v);
        vec_t r;
        r.op = op; r.data = d; r.usec = u; r.cin = cin; r.acc = a;
        r.c = c; r.z = z; r.n = n; r.v = v;
        return r;
    endfunction

    task automatic do_cmd(input vec_t v, input string tag);
        int waitc = 0;
        while (!cmd_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        chk({tag, "_ready_wait"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_usec  = v.usec;
        @(posedge clk); #1;
        // Junk on cmd_* while in EXEC must neither be accepted nor reach as_*.
        cmd_op   = ~v.op;
        cmd_data = ~v.data;
        cmd_usec = ~v.usec;
        #1;
        chk({tag, "_exec_busy"},  busy, 1);
        chk({tag, "_exec_ready"}, cmd_ready, 0);
        chk({tag, "_exec_rsp"},   rsp_valid, 0);
        chk({tag, "_as_a"},       as_a, model_acc);
        chk({tag, "_as_b"},       as_b, v.data);
        chk({tag, "_as_op"},      as_op, v.op[1]);
        chk({tag, "_as_cin"},     as_cin, v.cin);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, "_rsp"},    rsp_valid, 1);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_acc"},    acc, v.acc);
        chk({tag, "_flag_c"}, flag_c, v.c);
        chk({tag, "_flag_z"}, flag_z, v.z);
        chk({tag, "_flag_n"}, flag_n, v.n);
        chk({tag, "_flag_v"}, flag_v, v.v);
        model_acc = v.acc;
        @(posedge clk); #1;
        chk({tag, "_rsp_one_cycle"}, rsp_valid, 0);
        chk({tag, "_idle_ready"},    cmd_ready, 1);
    endtask

    initial begin
        int n_acc;
        int n_rsp;
        int acc_cyc [4];
        int rsp_cyc [4];

        vecs[0]  = mk(OP_LOAD,  8'h37, 1'b0, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(OP_ADD,   8'h05, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(OP_LOAD,  8'h30, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(OP_SUB,   8'h06, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(OP_SUB,   8'h40, 1'b0, 1'b0, 8'hEA, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(OP_LOAD,  8'h70, 1'b1, 1'b1, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(OP_ADD,   8'h10, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(OP_LOAD,  8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[8]  = mk(OP_ADD,   8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(OP_ADD,   8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(OP_LOAD,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(OP_SUB,   8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk(OP_SUB,   8'h00, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(OP_LOAD,  8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(OP_SUB,   8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(OP_LOAD,  8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[16] = mk(OP_ADD,   8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[17] = mk(OP_CLEAR, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'h00;
        cmd_usec  = 1'b0;
        model_acc = 8'h00;
        #12;
        chk("rst_acc",   acc, 8'h00);
        chk("rst_flags", {4'h0, flag_c, flag_z, flag_n, flag_v}, 8'h00);
        chk("rst_as_a",  as_a, 8'h00);
        chk("rst_as_b",  as_b, 8'h00);
        chk("rst_as_ctl", {6'h0, as_cin, as_op}, 8'h00);
        chk("rst_rsp",   rsp_valid, 0);
        chk("rst_busy",  busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 18; i++) begin
            do_cmd(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted in EXEC discards the command.
        do_cmd(mk(OP_LOAD, 8'hC0, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0), "pre_rst");
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 8'hC0;
        cmd_usec  = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("midrst_in_exec", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_acc",   acc, 8'h00);
        chk("midrst_flags", {4'h0, flag_c, flag_z, flag_n, flag_v}, 8'h00);
        chk("midrst_as_a",  as_a, 8'h00);
        chk("midrst_as_b",  as_b, 8'h00);
        chk("midrst_rsp",   rsp_valid, 0);
        chk("midrst_busy",  busy, 0);
        model_acc = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst_hold_rsp%0d", k), rsp_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("postrst_ready%0d", k), cmd_ready, 1);
            chk($sformatf("postrst_rsp%0d", k),   rsp_valid, 0);
            chk($sformatf("postrst_acc%0d", k),   acc, 8'h00);
        end
        do_cmd(mk(OP_ADD, 8'h07, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0), "postrst_add");

        // Back-to-back ADD 0x01 with cmd_valid held high.
        do_cmd(mk(OP_LOAD, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0), "b2b_load");
        cmd_op    = OP_ADD;
        cmd_data  = 8'h01;
        cmd_usec  = 1'b0;
        cmd_valid = 1'b1;
        n_acc = 0;
        n_rsp = 0;
        for (int cyc = 0; cyc < 30 && n_rsp < 4; cyc++) begin
            if (cmd_valid && cmd_ready) begin
                if (n_acc < 4) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (rsp_valid) begin
                if (n_rsp < 4) rsp_cyc[n_rsp] = cyc;
                n_rsp++;
            end
            @(posedge clk); #1;
            if (n_acc >= 4) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", n_acc[7:0], 8'd4);
        chk("b2b_rsps",    n_rsp[7:0], 8'd4);
        if (n_acc == 4 && n_rsp == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b2b_latency%0d", k), 8'(rsp_cyc[k] - acc_cyc[k]), 8'd2);
                if (k > 0) chk($sformatf("b2b_gap%0d", k), 8'(acc_cyc[k] - acc_cyc[k-1]), 8'd2);
            end
        end
        chk("b2b_acc", acc, 8'h14);
        @(posedge clk); #1;
        chk("b2b_idle_rsp", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_seq8.md
ACC_SEQ8 -- requirements
Module: acc_seq8

Interface
REQ-001 Parameter: none; the datapath width is fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-007 cmd_data  input  8  operand B, or the load value.
REQ-008 cmd_usec  input  1  1 uses flag_c as carry/borrow-in; 0 uses carry-in 0.
REQ-009 as_a, as_b  output  8 each  operands driven to the external add/sub unit.
REQ-010 as_cin  output  1  carry/borrow-in to the add/sub unit.
REQ-011 as_op  output  1  0 add, 1 subtract.
REQ-012 as_result  input  8  result from the add/sub unit.
REQ-013 as_cout  input  1  carry-out (add) or borrow-out (sub) from the add/sub unit.
REQ-014 acc  output  8  accumulator.
REQ-015 flag_c, flag_z, flag_n, flag_v  output  1 each  carry/borrow, zero, negative, signed overflow.
REQ-016 rsp_valid  output  1  one-cycle pulse: acc and flags are updated.
REQ-017 busy  output  1  high in EXEC.

Function
REQ-018 The external add/sub unit is purely combinational:
- op=0: {cout,result} = a+b+cin.
- op=1: result = a-b-cin (mod 256); cout = 1 when a borrow occurs.
REQ-019 FSM states are IDLE, EXEC and DONE; the reset state is IDLE.
REQ-020 cmd_ready is 1 in IDLE and DONE and 0 in EXEC.
REQ-021 A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1; the FSM then goes to EXEC.
REQ-022 On acceptance, the block registers the following:
- as_a = acc;
- as_b = cmd_data;
- as_op = cmd_op[1];
- as_cin = cmd_usec & flag_c;
- cmd_op and cmd_data are stored internally.
REQ-023 as_* outputs hold their value until the next acceptance; no combinational path exists from cmd_* to as_*.
REQ-024 At the end of EXEC the block updates acc and the flags, then goes to DONE.
- In DONE, rsp_valid=1 for exactly one cycle.
- Latency: acceptance edge T gives rsp_valid high in cycle T+2.
REQ-025 DONE returns to IDLE, or to EXEC if a new command is accepted in DONE; peak throughput is one command per 2 cycles.
REQ-026 ADD/SUB capture:
- acc = as_result; flag_c = as_cout;
- flag_z = (as_result==0); flag_n = as_result[7].
REQ-027 flag_v is computed from as_a, as_b and as_result:
- ADD: flag_v = (as_a[7]==as_b[7]) & (as_result[7]!=as_a[7]).
- SUB: flag_v = (as_a[7]!=as_b[7]) & (as_result[7]!=as_a[7]).
REQ-028 LOAD: acc = stored cmd_data; flag_z and flag_n are updated from it; flag_c and flag_v are unchanged; as_* are still driven per REQ-022.
REQ-029 CLEAR: acc = 0, flag_z = 1, and flag_c, flag_n, flag_v are cleared.
REQ-030 cmd_usec has effect only for ADD and SUB; carry/borrow chaining across commands uses flag_c as updated by the previous command.
REQ-031 Wrap-around: results are taken modulo 256, and the ninth bit appears only in flag_c.
REQ-032 cmd_valid while cmd_ready=0 is ignored; cmd_* may change freely in EXEC.

Reset
REQ-033 While rst_n=0, the block immediately, regardless of clk, forces:
- state = IDLE;
- acc, as_a, as_b = 0;
- as_cin, as_op = 0;
- all flags = 0; rsp_valid = 0; busy = 0.
REQ-034 When reset asserts mid-operation, the in-flight command is discarded and no rsp_valid is produced for it.
REQ-035 After rst_n deasserts, cmd_ready=1 on the first clock edge.

Verification
REQ-036 LOAD 0x37, then ADD 0x05 with usec=0 -> acc=0x3C, c=0, z=0, n=0, v=0; rsp_valid two cycles after each acceptance.
REQ-037 LOAD 0x30, then SUB 0x06 -> acc=0x2A, c=0; then SUB 0x40 -> acc=0xEA, c=1, n=1, v=0.
REQ-038 LOAD 0x70, then ADD 0x10 -> acc=0x80, n=1, v=1, c=0; LOAD 0xFF, then ADD 0x01 -> acc=0x00, z=1, c=1.
REQ-039 Chain: after the 0xFF+0x01 case above, ADD 0x00 with usec=1 -> as_cin=1, acc=0x01, c=0.
REQ-040 Back-to-back: cmd_valid held high with 4 ADD 0x01 commands -> acceptances every 2 cycles, 4 rsp_valid pulses, acc rises by 4.
REQ-041 Assert rst_n=0 during EXEC -> acc, flags and rsp_valid go to 0 before the next edge; no response is produced; cmd_ready=1 after release.
